ttlc_seq: RTL
=============

TTLC_SEQ -- requirements
Module: ttlc_seq

Interface
REQ-001 Parameter RESET_PC, default 8'h00, program counter value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4, return-stack entries; used only when TTLC_SEQ_STACK_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level; 1 = fetch/execute continuously, 0 = stop after current instruction.
REQ-006 prog_req  output  1  instruction fetch request, held until prog_ack.
REQ-007 prog_addr  output  8  instruction address (PC) during fetch.
REQ-008 prog_ack  input  1  fetch complete; prog_data valid this cycle.
REQ-009 prog_data  input  12  instruction: [11:8] opcode, [7:0] I/O bit address or jump target.
REQ-010 io_addr  output  8  bit address to the I/O module.
REQ-011 io_write  output  1  one-cycle write strobe for one bit.
REQ-012 io_wdata  output  1  write data bit.
REQ-013 io_rdata  input  1  combinational read-back of bit at io_addr.
REQ-014 rr_value  output  1  result register, fed back to the I/O module.
REQ-015 flag_o, flag_f, jmp_flag, rtn_flag  output  1 each  one-cycle pulses.

Function
REQ-016 FSM states IDLE, FETCH, EXEC; IDLE->FETCH when run=1; FETCH->EXEC on prog_ack (IR <= prog_data); EXEC->FETCH if run=1, else IDLE.
REQ-017 FETCH: prog_req=1, prog_addr=PC; prog_ack in the first FETCH cycle is accepted (zero wait states); prog_ack outside FETCH is ignored.
REQ-018 EXEC lasts exactly one cycle; io_addr=IR[7:0] in EXEC, 0 otherwise; PC <= PC+1 (8-bit, 255 wraps to 0) unless a jump is taken.
REQ-019 Effective data D = io_rdata AND IEN.
REQ-020 Opcodes: 0 NOPO (flag_o pulse), 1 LD RR<=D, 2 LDC RR<=~D, 3 AND RR<=RR&D, 4 ANDC RR<=RR&~D, 5 OR RR<=RR|D, 6 ORC RR<=RR|~D, 7 XNOR RR<=~(RR^D), 8 STO, 9 STOC, A IEN<=D, B OEN<=D, C JMP, D RTN, E SKZ, F NOPF (flag_f pulse).
REQ-021 STO/STOC: io_write=OEN in EXEC, io_wdata=RR/~RR (pre-update RR); io_write never asserted outside EXEC.
REQ-022 SKZ: if RR=0 set skip; RTN: rtn_flag pulse, set skip (without stack macro).
REQ-023 JMP: jmp_flag pulse, PC <= IR[7:0].
REQ-024 Skipped instruction: still fetched, EXEC has no RR/IEN/OEN/PC-target/io_write/flag effects, PC<=PC+1, skip cleared.
REQ-025 run falling during FETCH or EXEC: current instruction completes, then IDLE; PC holds next address.

Reset
REQ-026 rst asserted: immediately state=IDLE, PC=RESET_PC, RR=0, IEN=1, OEN=1, skip=0, IR=0, all outputs 0 (prog_addr=RESET_PC); mid-fetch reset drops prog_req without waiting for prog_ack.

Configuration
REQ-027 Macro TTLC_SEQ_STACK_EN defined: JMP also pushes PC+1 onto a STACK_DEPTH return stack (full: deepest entry discarded); RTN pops into PC with no skip; RTN on empty stack behaves as REQ-022. Undefined: no stack logic, JMP/RTN per REQ-022/023.

Verification
REQ-028 Reset, run=1, prog_ack same cycle: program {LD 5, STO 9} with io_rdata=1 at addr 5 -> io_write=1, io_addr=9, io_wdata=1 in second EXEC; rr_value=1.
REQ-029 IEN 3 with bit3=0, then LD 5 (bit5=1) -> RR=0; OEN with D=0 then STO -> io_write stays 0.
REQ-030 RR=0, SKZ then LDC 7 -> LDC has no effect, RR=0, PC advanced by 2.
REQ-031 JMP 8'h40 at PC=8'hFF -> jmp_flag pulse, next prog_addr=8'h40; NOP at PC=8'hFF -> next prog_addr=8'h00.
REQ-032 prog_ack delayed 3 cycles, rst pulsed in 2nd FETCH cycle -> prog_req low same cycle, prog_addr=RESET_PC.
REQ-033 With TTLC_SEQ_STACK_EN: 5 nested JMPs then 5 RTNs -> first 4 return to pushed addresses in LIFO order, 5th pulses rtn_flag and skips.

Source files
------------

// File: rtl/ttlc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ttlc_seq_if
// Purpose  : Program-fetch, bit-I/O and status bundle of the ttlc_seq sequencer.
// Revision : 1.0
// ============================================================================
interface ttlc_seq_if;
  logic        run;
  logic        prog_req;
  logic [7:0]  prog_addr;
  logic        prog_ack;
  logic [11:0] prog_data;
  logic [7:0]  io_addr;
  logic        io_write;
  logic        io_wdata;
  logic        io_rdata;
  logic        rr_value;
  logic        flag_o;
  logic        flag_f;
  logic        jmp_flag;
  logic        rtn_flag;

  modport master (
    output run, prog_ack, prog_data, io_rdata,
    input  prog_req, prog_addr, io_addr, io_write, io_wdata, rr_value,
           flag_o, flag_f, jmp_flag, rtn_flag
  );

  modport slave (
    input  run, prog_ack, prog_data, io_rdata,
    output prog_req, prog_addr, io_addr, io_write, io_wdata, rr_value,
           flag_o, flag_f, jmp_flag, rtn_flag
  );
endinterface
`default_nettype wire

// File: rtl/ttlc_seq.sv
`default_nettype none
// ============================================================================
// Module   : ttlc_seq
// Purpose  : IDLE/FETCH/EXEC sequencer for a 1-bit controller; defining
//            TTLC_SEQ_STACK_EN adds a JMP/RTN return stack.
// Revision : 1.0
// ============================================================================
module ttlc_seq #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  ttlc_seq_if.slave bus_io
);

  if (STACK_DEPTH == 0) begin : g_depth_check
    $error("ttlc_seq: STACK_DEPTH must be at least 1");
  end

  localparam logic [3:0] OP_NOPO = 4'h0, OP_LD  = 4'h1, OP_LDC  = 4'h2, OP_AND = 4'h3,
                         OP_ANDC = 4'h4, OP_OR  = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
                         OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN = 4'hA, OP_OEN = 4'hB,
                         OP_JMP  = 4'hC, OP_RTN = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [11:0] ir_q;
  logic        rr_q, ien_q, oen_q, skip_q;
  logic [7:0]  io_addr_q;
  logic        io_write_q, io_wdata_q;
  logic        flag_o_q, flag_f_q, jmp_flag_q, rtn_flag_q;

  logic [3:0]  fetch_op;
  logic [3:0]  exec_op;
  logic        data_eff;
  logic [7:0]  pc_inc;

`ifdef TTLC_SEQ_STACK_EN
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
  logic [7:0]      stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
`endif

  assign fetch_op = bus_io.prog_data[11:8];
  assign exec_op  = ir_q[11:8];
  assign data_eff = bus_io.io_rdata & ien_q;
  assign pc_inc   = pc_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      rr_q       <= 1'b0;
      ien_q      <= 1'b1;
      oen_q      <= 1'b1;
      skip_q     <= 1'b0;
      io_addr_q  <= '0;
      io_write_q <= 1'b0;
      io_wdata_q <= 1'b0;
      flag_o_q   <= 1'b0;
      flag_f_q   <= 1'b0;
      jmp_flag_q <= 1'b0;
      rtn_flag_q <= 1'b0;
`ifdef TTLC_SEQ_STACK_EN
      sp_q       <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          // Execute-cycle outputs are decoded here so they are registered for EXEC.
          if (bus_io.prog_ack) begin
            state_q   <= S_EXEC;
            ir_q      <= bus_io.prog_data;
            io_addr_q <= bus_io.prog_data[7:0];
            if (!skip_q) begin
              io_write_q <= oen_q & ((fetch_op == OP_STO) | (fetch_op == OP_STOC));
              io_wdata_q <= (fetch_op == OP_STOC) ? ~rr_q :
                            (fetch_op == OP_STO)  ?  rr_q : 1'b0;
              flag_o_q   <= (fetch_op == OP_NOPO);
              flag_f_q   <= (fetch_op == OP_NOPF);
              jmp_flag_q <= (fetch_op == OP_JMP);
              rtn_flag_q <= (fetch_op == OP_RTN);
            end
          end
        end
        S_EXEC: begin
          io_addr_q  <= '0;
          io_write_q <= 1'b0;
          io_wdata_q <= 1'b0;
          flag_o_q   <= 1'b0;
          flag_f_q   <= 1'b0;
          jmp_flag_q <= 1'b0;
          rtn_flag_q <= 1'b0;
          pc_q       <= pc_inc;
          skip_q     <= 1'b0;
          state_q    <= bus_io.run ? S_FETCH : S_IDLE;
          if (!skip_q) begin
            case (exec_op)
              OP_LD:   rr_q  <= data_eff;
              OP_LDC:  rr_q  <= ~data_eff;
              OP_AND:  rr_q  <= rr_q & data_eff;
              OP_ANDC: rr_q  <= rr_q & ~data_eff;
              OP_OR:   rr_q  <= rr_q | data_eff;
              OP_ORC:  rr_q  <= rr_q | ~data_eff;
              OP_XNOR: rr_q  <= ~(rr_q ^ data_eff);
              OP_IEN:  ien_q <= data_eff;
              OP_OEN:  oen_q <= data_eff;
              OP_JMP: begin
                pc_q <= ir_q[7:0];
`ifdef TTLC_SEQ_STACK_EN
                // Push shifts toward the bottom; a full stack loses its oldest entry.
                for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) stack_q[i] <= stack_q[i-1];
                stack_q[0] <= pc_inc;
                if (sp_q != SP_W'(STACK_DEPTH)) sp_q <= sp_q + SP_W'(1);
`endif
              end
              OP_RTN: begin
`ifdef TTLC_SEQ_STACK_EN
                if (sp_q != '0) begin
                  pc_q <= stack_q[0];
                  for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stack_q[i] <= stack_q[i+1];
                  stack_q[STACK_DEPTH-1] <= '0;
                  sp_q <= sp_q - SP_W'(1);
                end else begin
                  skip_q <= 1'b1;
                end
`else
                skip_q <= 1'b1;
`endif
              end
              OP_SKZ:  if (!rr_q) skip_q <= 1'b1;
              default: ;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.prog_req  = (state_q == S_FETCH);
  assign bus_io.prog_addr = pc_q;
  assign bus_io.io_addr   = io_addr_q;
  assign bus_io.io_write  = io_write_q;
  assign bus_io.io_wdata  = io_wdata_q;
  assign bus_io.rr_value  = rr_q;
  assign bus_io.flag_o    = flag_o_q;
  assign bus_io.flag_f    = flag_f_q;
  assign bus_io.jmp_flag  = jmp_flag_q;
  assign bus_io.rtn_flag  = rtn_flag_q;

endmodule
`default_nettype wire
